// File: rtl/ofs_fim_if_pkg.sv
// ofs_fim_if_pkg
// Shared FIM interface types. The PCIe TX AXI-S beat is a flat packed
// struct, so one beat moves through a single register.
//   AXIS_PCIE_DW    : TLP data width of one beat
//   AXIS_PCIE_TX_UW : TX sideband (tuser) width
//   t_axis_pcie_tx  : tvalid, tdata, tlast, tuser of one TX beat
`timescale 1ns/1ps
package ofs_fim_if_pkg;

   localparam int AXIS_PCIE_DW    = 64;
   localparam int AXIS_PCIE_TX_UW = 8;

   typedef struct packed {
      logic                       tvalid;
      logic [AXIS_PCIE_DW-1:0]    tdata;
      logic                       tlast;
      logic [AXIS_PCIE_TX_UW-1:0] tuser;
   } t_axis_pcie_tx;

endpackage

// File: rtl/pcie_tx_rr_arb.sv
// pcie_tx_rr_arb
// Combinational masked round-robin picker. The search starts at the port
// just above last_grant and wraps, so the most recently served port has
// the lowest priority. It holds no state, which keeps it reusable on the
// RX side.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the most recently served port
//   gnt        out NUM_REQ  one-hot winner (all zero when no request)
//   gnt_idx    out IDX_W    binary index of the winner
//   any_req    out 1        at least one request is pending
`timescale 1ns/1ps
module pcie_tx_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any_req
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] masked_req;
   logic [NUM_REQ-1:0] pick_req;

   // Ports strictly above last_grant form the first-priority window
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask[i] = (i > int'(last_grant));
      end
   end

   // Use the upper window when it holds any request, otherwise wrap to all
   assign masked_req = req & upper_mask;
   assign pick_req   = (|masked_req) ? masked_req : req;
   assign any_req    = |req;

   // Lowest set bit of the chosen window wins; the descending loop lets the
   // lowest index overwrite higher ones
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick_req[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb
// Packet-boundary-aware round-robin merge of NUM_REQ PCIe TX AXI-S streams
// into one registered output stream. A grant is held from the first beat of
// a TLP through its tlast beat so TLPs never interleave.
// Ports:
//   clk          in  1        block clock
//   rst_n        in  1        asynchronous active-low reset
//   s_if         in  NUM_REQ  requester streams
//   s_if_tready  out NUM_REQ  per-requester ready, at most one bit high
//   m_if         out 1 beat   merged registered stream
//   m_if_tready  in  1        downstream ready
//   cur_grant    out IDX_W    port currently or last granted (debug)
//   locked       out 1        multi-beat TLP in progress
`timescale 1ns/1ps
module pcie_tx_arb
   import ofs_fim_if_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter bit TREADY_RST_VAL = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  t_axis_pcie_tx              s_if [NUM_REQ],
   output logic [NUM_REQ-1:0]         s_if_tready,
   output t_axis_pcie_tx              m_if,
   input  logic                       m_if_tready,
   output logic [$clog2(NUM_REQ)-1:0] cur_grant,
   output logic                       locked
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   lock_port;
   logic [IDX_W-1:0]   sel_port;
   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               out_ready;
   logic               accept;
   t_axis_pcie_tx      sel_beat;

   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_vec[i] = s_if[i].tvalid;
      end
   end

   pcie_tx_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .req        (req_vec),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .gnt_idx    (arb_idx),
      .any_req    (arb_any)
   );

   // The output register can take a beat when empty or draining this cycle
   assign out_ready = !m_if.tvalid || m_if_tready;

   // Ready is steered to exactly one port: the fresh winner in IDLE or the
   // locked port mid-TLP. During reset only the optional default port 0 may
   // see ready.
   always_comb begin
      s_if_tready = '0;
      if (!rst_n) begin
         s_if_tready[0] = TREADY_RST_VAL;
      end else if (out_ready) begin
         if (state == ST_IDLE) begin
            if (arb_any) begin
               s_if_tready = arb_gnt;
            end
         end else begin
            s_if_tready[lock_port] = 1'b1;
         end
      end
   end

   assign sel_port = (state == ST_IDLE) ? arb_idx : lock_port;
   assign sel_beat = s_if[sel_port];
   assign accept   = sel_beat.tvalid && s_if_tready[sel_port];
   assign locked   = (state == ST_LOCKED);

   // Grant bookkeeping: a non-tlast beat locks onto its port, a tlast beat
   // releases back to IDLE where the next search starts after this port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         lock_port  <= '0;
         cur_grant  <= '0;
      end else if (accept) begin
         last_grant <= sel_port;
         lock_port  <= sel_port;
         cur_grant  <= sel_port;
         state      <= sel_beat.tlast ? ST_IDLE : ST_LOCKED;
      end
   end

   // Single registered output stage; payload only changes on acceptance,
   // which cannot happen while the downstream is stalling a valid beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_if <= '0;
      end else if (accept) begin
         m_if.tvalid <= 1'b1;
         m_if.tdata  <= sel_beat.tdata;
         m_if.tlast  <= sel_beat.tlast;
         m_if.tuser  <= sel_beat.tuser;
      end else if (out_ready) begin
         m_if.tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb_pcie_tx_arb
// Directed bench for pcie_tx_arb. Per-port source queues feed the requester
// streams; the expected merged beat order is pushed into a scoreboard queue
// as stimulus is issued, and a monitor pops and compares on every m_if
// handshake.
`timescale 1ns/1ps
module tb_pcie_tx_arb;
   import ofs_fim_if_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef struct packed {
      logic [AXIS_PCIE_DW-1:0]    tdata;
      logic                       tlast;
      logic [AXIS_PCIE_TX_UW-1:0] tuser;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   t_axis_pcie_tx      s_if [NUM_REQ];
   logic [NUM_REQ-1:0] s_if_tready;
   t_axis_pcie_tx      m_if;
   logic               m_if_tready;
   logic [IDX_W-1:0]   cur_grant;
   logic               locked;

   beat_t              srcq [NUM_REQ][$];
   beat_t              exp_q [$];
   int                 beat_cyc [$];
   logic [NUM_REQ-1:0] src_en = '0;
   logic               rand_ready = 1'b0;
   logic               watch_p0 = 1'b0;
   int                 cyc = 0;
   int                 checks = 0;
   int                 fails = 0;

   always #5 clk = ~clk;

   pcie_tx_arb #(
      .NUM_REQ        (NUM_REQ),
      .TREADY_RST_VAL (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_if        (s_if),
      .s_if_tready (s_if_tready),
      .m_if        (m_if),
      .m_if_tready (m_if_tready),
      .cur_grant   (cur_grant),
      .locked      (locked)
   );

   function automatic beat_t mkBeat(int port, int tlp, int idx, int nbeats);
      beat_t b;
      b.tdata = 64'hA5A5_0000_0000_0000 | (64'(port) << 32) | (64'(tlp) << 16) | 64'(idx);
      b.tlast = (idx == nbeats - 1);
      b.tuser = 8'(port * 16 + tlp * 4 + idx);
      return b;
   endfunction

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(int port, int tlp, int nbeats);
      for (int b = 0; b < nbeats; b++) srcq[port].push_back(mkBeat(port, tlp, b, nbeats));
   endtask

   task automatic expectTlp(int port, int tlp, int nbeats);
      for (int b = 0; b < nbeats; b++) exp_q.push_back(mkBeat(port, tlp, b, nbeats));
   endtask

   task automatic driveSources();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_en[i] && srcq[i].size() > 0) begin
            s_if[i].tvalid = 1'b1;
            s_if[i].tdata  = srcq[i][0].tdata;
            s_if[i].tlast  = srcq[i][0].tlast;
            s_if[i].tuser  = srcq[i][0].tuser;
         end else begin
            s_if[i] = '0;
         end
      end
   endtask

   // Stimulus actions happen at posedge+2, between the source pop (+1)
   // and the source redrive (+3)
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic waitDrain(string name, int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic waitSrcSize(string name, int port, int size, int budget);
      int n = 0;
      while (srcq[port].size() != size && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput(name, 64'(srcq[port].size()), 64'(size));
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      src_en = '0;
      for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
      exp_q.delete();
      tick(3);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Source driver: a beat leaves its queue when it was handshaken at the
   // preceding clock edge
   initial begin
      logic [NUM_REQ-1:0] fired;
      fired = '0;
      m_if_tready = 1'b1;
      driveSources();
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) fired[i] = s_if[i].tvalid && s_if_tready[i];
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (fired[i] && rst_n && srcq[i].size() > 0) void'(srcq[i].pop_front());
         end
         #2;
         m_if_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         driveSources();
      end
   end

   // Monitor: scoreboard compare on each m_if handshake plus per-cycle
   // protocol checks
   initial begin
      t_axis_pcie_tx prev_m;
      logic          prev_stall;
      beat_t         e;
      prev_m = '0;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            checkOutput("tready_onehot", 64'($countones(s_if_tready) <= 1), 64'd1);
            if (watch_p0) checkOutput("p0_tready_while_locked", 64'(s_if_tready[0]), 64'd0);
            if (prev_stall) checkOutput("m_if_stable_in_stall", 64'(m_if === prev_m), 64'd1);
            if (m_if.tvalid && m_if_tready) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_beat", m_if.tdata, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("tdata", m_if.tdata, e.tdata);
                  checkOutput("tlast", 64'(m_if.tlast), 64'(e.tlast));
                  checkOutput("tuser", 64'(m_if.tuser), 64'(e.tuser));
                  beat_cyc.push_back(cyc);
               end
            end
            prev_stall = m_if.tvalid && !m_if_tready;
            prev_m = m_if;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset values
      #12;
      checkOutput("rst_tvalid", 64'(m_if.tvalid), 64'd0);
      checkOutput("rst_tdata", m_if.tdata, 64'd0);
      checkOutput("rst_tlast", 64'(m_if.tlast), 64'd0);
      checkOutput("rst_tuser", 64'(m_if.tuser), 64'd0);
      checkOutput("rst_locked", 64'(locked), 64'd0);
      checkOutput("rst_cur_grant", 64'(cur_grant), 64'd0);
      checkOutput("rst_tready", 64'(s_if_tready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Lone requester, back-to-back TLPs of 3, 1 and 2 beats
      $display("[TB] single requester back-to-back");
      applyStimulus(2, 0, 3); applyStimulus(2, 1, 1); applyStimulus(2, 2, 2);
      expectTlp(2, 0, 3); expectTlp(2, 1, 1); expectTlp(2, 2, 2);
      beat_cyc.delete();
      src_en = 4'b0100;
      waitDrain("t1", 50);
      checkOutput("t1_beat_count", 64'(beat_cyc.size()), 64'd6);
      if (beat_cyc.size() == 6) checkOutput("t1_no_bubbles", 64'(beat_cyc[5] - beat_cyc[0]), 64'd5);
      src_en = '0;

      // Fairness from reset: port 0 first, then strict rotation
      $display("[TB] fairness");
      resetDut();
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < NUM_REQ; p++) begin
            applyStimulus(p, r, 2);
            expectTlp(p, r, 2);
         end
      end
      src_en = '1;
      waitDrain("t2", 100);
      checkOutput("t2_cur_grant", 64'(cur_grant), 64'd3);
      src_en = '0;

      // Lock held across an upstream gap while port 0 waits
      $display("[TB] lock with upstream gap");
      applyStimulus(1, 0, 2); applyStimulus(0, 3, 1);
      expectTlp(1, 0, 2); expectTlp(0, 3, 1);
      src_en = 4'b0010;
      waitSrcSize("t3_first_beat", 1, 1, 20);
      src_en = 4'b0001;
      watch_p0 = 1'b1;
      tick(1);
      checkOutput("t3_locked", 64'(locked), 64'd1);
      checkOutput("t3_cur_grant", 64'(cur_grant), 64'd1);
      tick(2);
      src_en = 4'b0011;
      waitSrcSize("t3_second_beat", 1, 0, 20);
      watch_p0 = 1'b0;
      waitDrain("t3", 50);
      src_en = '0;

      // Random backpressure, all ports busy; rotation resumes after port 0
      $display("[TB] backpressure");
      for (int r = 0; r < 2; r++) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            applyStimulus(k % NUM_REQ, r, 2);
            expectTlp(k % NUM_REQ, r, 2);
         end
      end
      rand_ready = 1'b1;
      src_en = '1;
      waitDrain("t4", 400);
      rand_ready = 1'b0;
      src_en = '0;
      tick(1);

      // Reset during beat 2 of a 4-beat TLP from port 3
      $display("[TB] reset mid-TLP");
      applyStimulus(3, 0, 4);
      src_en = 4'b1000;
      waitSrcSize("t5_beat1_taken", 3, 3, 20);
      rst_n = 1'b0;
      src_en = '0;
      srcq[3].delete();
      #1;
      checkOutput("t5_tvalid_in_reset", 64'(m_if.tvalid), 64'd0);
      checkOutput("t5_locked_in_reset", 64'(locked), 64'd0);
      checkOutput("t5_tready_in_reset", 64'(s_if_tready), 64'd0);
      checkOutput("t5_cur_grant_in_reset", 64'(cur_grant), 64'd0);
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      checkOutput("t5_locked_after", 64'(locked), 64'd0);
      applyStimulus(2, 1, 1); applyStimulus(0, 1, 1);
      expectTlp(0, 1, 1); expectTlp(2, 1, 1);
      src_en = 4'b0101;
      waitDrain("t5", 50);
      src_en = '0;

      // Port 1 raises tvalid in the cycle port 0's tlast is accepted
      $display("[TB] simultaneous end and request");
      applyStimulus(0, 2, 2); applyStimulus(1, 2, 1);
      expectTlp(0, 2, 2); expectTlp(1, 2, 1);
      beat_cyc.delete();
      src_en = 4'b0001;
      waitSrcSize("t6_first_beat", 0, 1, 20);
      src_en = 4'b0011;
      waitDrain("t6", 50);
      checkOutput("t6_beat_count", 64'(beat_cyc.size()), 64'd3);
      if (beat_cyc.size() == 3) checkOutput("t6_handover_gap", 64'(beat_cyc[2] - beat_cyc[1]), 64'd1);
      checkOutput("t6_cur_grant", 64'(cur_grant), 64'd1);
      src_en = '0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pcie_tx_arb.md
# pcie_tx_arb

Packet-boundary-aware round-robin arbiter that merges NUM_REQ upstream PCIe TX AXI-S streams (t_axis_pcie_tx) into one stream toward the PCIe TX pipeline register chain. A grant is held for a whole TLP, from first beat through the tlast beat, so TLPs never interleave. The output is a single registered stage, so the merged stream meets timing before entering the downstream pipeline.

## Interface
- NUM_REQ, 4, number of requesters (2-8)
- TREADY_RST_VAL, 0, 0: all s_if_tready low during reset; 1: tready of the reset-time default port (port 0) high during reset
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- s_if  in  t_axis_pcie_tx[NUM_REQ]  requester streams (tvalid, tdata, tlast, tuser)
- s_if_tready  out  NUM_REQ  per-requester ready; at most one bit high at any time
- m_if  out  t_axis_pcie_tx  merged stream
- m_if_tready  in  1  downstream ready
- cur_grant  out  $clog2(NUM_REQ)  index of the port currently granted or last granted (debug)
- locked  out  1  high while a multi-beat TLP is in progress

## Operation
- States: IDLE and LOCKED.
- **IDLE**
  - Arbitrate combinationally among ports with s_if[i].tvalid=1.
  - Search starts at last_grant+1 mod NUM_REQ and is round-robin.
  - The winner w gets s_if_tready[w] = out_ready. All other readys are 0.
- **Beat acceptance**
  - A beat is accepted when s_if[w].tvalid && s_if_tready[w].
  - On acceptance, last_grant <= w.
  - If the accepted beat has tlast=0, go to LOCKED with lock_port <= w.
  - If it has tlast=1, stay in IDLE. A single-beat TLP therefore never locks.
- **LOCKED**
  - Only lock_port sees s_if_tready = out_ready. All other ports see 0.
  - Acceptance of a beat with tlast=1 returns the block to IDLE.
  - The requester deasserting tvalid mid-TLP causes a stall. The lock is held and there is no timeout.
- **Output stage**
  - out_ready = !m_if.tvalid || m_if_tready.
  - An accepted beat loads m_if (tvalid=1; tdata, tlast, tuser copied unchanged).
  - If out_ready and no beat is accepted, m_if.tvalid <= 0.
  - Full throughput: one beat per cycle when m_if_tready is held high.
- **Fairness**
  - After a port finishes a TLP, every other pending port is served before it is served again.
  - A lone requester may send back-to-back TLPs with no idle cycle.
- **Reset** (asynchronous, any time, including mid-TLP)
  - Outputs: m_if.tvalid=0, m_if.tlast=0, m_if.tdata=0, m_if.tuser=0.
  - State=IDLE, last_grant=NUM_REQ-1 (port 0 wins first), cur_grant=0, locked=0.
  - s_if_tready is all 0 (or bit 0 only, when TREADY_RST_VAL=1).
  - A partially transferred TLP is abandoned. Upstream sources reset on the same rst_n.

## Timing
- Latency: accepted beat appears on m_if one cycle later.
- s_if_tready is combinational from m_if_tready, m_if.tvalid, state and s_if[*].tvalid. There is no combinational path from any s_if input to m_if.
- Arbitration inside IDLE is zero-cycle. The cycle after a tlast beat is accepted, a new winner may be accepted.
- Simultaneous tlast acceptance and new requests resolve as follows: that same cycle, the new request is not yet considered. The next cycle, arbitration uses the updated last_grant.
- **Downstream stall** (m_if_tready=0 with m_if.tvalid=1)
  - All s_if_tready are 0.
  - m_if holds stable.
  - State and last_grant do not change.
- AXI-S rule: m_if.tvalid, once high, is never dropped and m_if payload never changes until m_if_tready.

## Structure
- t_axis_pcie_tx, AXIS_PCIE_DW and AXIS_PCIE_TX_UW come from ofs_fim_if_pkg. No new typedefs are needed.
- The state enum (IDLE/LOCKED) stays local to the module.
- Sub-module pcie_tx_rr_arb: combinational masked round-robin picker.
  - Inputs: req[NUM_REQ], last_grant.
  - Outputs: gnt one-hot, gnt_idx, any_req.
  - Reusable for the RX side.
- The output register is inline. A downstream axis_register chain provides any further pipelining.

## Test plan
- **Single requester, back-to-back TLPs:** port 2 sends 3-beat, 1-beat, then 2-beat TLPs with m_if_tready=1 -> 6 contiguous m_if beats. tlast appears on beats 3, 4 and 6. tuser and tdata match. There are no bubbles.
- **Fairness:** ports 0-3 each hold tvalid with 2-beat TLPs after reset -> grant order 0,1,2,3,0,… and no beat interleaving within a TLP.
- **Lock with upstream gap:** port 1 sends beat 1 (tlast=0), drops tvalid for 3 cycles while port 0 is valid, then sends beat 2 (tlast=1) -> s_if_tready[0] stays 0 throughout and m_if carries port 1's beats only.
- **Backpressure:** random m_if_tready (50%) with 4 active ports -> no data loss or duplication (scoreboard per port), m_if stable while stalled, at most one s_if_tready high.
- **Reset mid-TLP:** assert rst_n low during beat 2 of a 4-beat TLP from port 3 -> m_if.tvalid=0 immediately. After release, port 0 wins if valid and locked=0.
- **Simultaneous end and request:** port 0 tlast accepted in the same cycle port 1 raises tvalid -> port 1's first beat is accepted the next cycle and appears on m_if one cycle after that.
